// File: rtl/pixel_simd_streamer.sv
// Frame reader: streams a HEIGHT x WIDTH 8-bit frame from word-organised memory
// as SIMD beats with sof/eol/eof markers over a valid/ready interface.
module pixel_simd_streamer #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int SIMD_WIDTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [8*SIMD_WIDTH-1:0] mem_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [8*SIMD_WIDTH-1:0] m_data,
  output logic                    m_sof,
  output logic                    m_eol,
  output logic                    m_eof
);

  localparam int DW    = 8 * SIMD_WIDTH;
  localparam int COLS  = WIDTH / SIMD_WIDTH;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } mark_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_vld_q, rd_vld_d;
  mark_t              rd_mark_q, rd_mark_d;
  logic [1:0][DW-1:0] fifo_data_q, fifo_data_d;
  mark_t [1:0]        fifo_mark_q, fifo_mark_d;
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;

  mark_t req_mark, out_mark;
  logic  hs, push, pop;

  // Output side: FIFO head, or the in-flight read word when the FIFO is empty.
  always_comb begin
    req_mark.sof = (row_q == '0) && (col_q == '0);
    req_mark.eol = (col_q == COL_LAST);
    req_mark.eof = req_mark.eol && (row_q == ROW_LAST);
    mem_req  = (state_q == RUN) && (({1'b0, cnt_q} + {2'b00, rd_vld_q}) < 3'd2);
    mem_addr = addr_q;
    busy     = busy_q;
    done     = done_q;
    m_valid  = (cnt_q != 2'd0) || rd_vld_q;
    m_data   = '0;
    out_mark = '0;
    if (cnt_q != 2'd0) begin
      m_data   = fifo_data_q[rd_ptr_q];
      out_mark = fifo_mark_q[rd_ptr_q];
    end else if (rd_vld_q) begin
      m_data   = mem_rdata;
      out_mark = rd_mark_q;
    end
    m_sof = out_mark.sof;
    m_eol = out_mark.eol;
    m_eof = out_mark.eof;
    hs    = m_valid && m_ready;
    pop   = hs && (cnt_q != 2'd0);
    // Arriving word is stored unless it bypasses straight out to a ready sink.
    push  = rd_vld_q && !((cnt_q == 2'd0) && m_ready);
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    rd_vld_d    = mem_req;
    rd_mark_d   = mem_req ? req_mark : rd_mark_q;
    fifo_data_d = fifo_data_q;
    fifo_mark_d = fifo_mark_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_rdata;
      fifo_mark_d[wr_ptr_q] = rd_mark_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        row_d   = '0;
        col_d   = '0;
        addr_d  = '0;
      end
      RUN: if (mem_req) begin
        addr_d = addr_q + ADDR_W'(1);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
          if (row_q == ROW_LAST) state_d = DRAIN;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      DRAIN: if (hs && m_eof) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_mark_q   <= '0;
      fifo_data_q <= '0;
      fifo_mark_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_mark_q   <= rd_mark_d;
      fifo_data_q <= fifo_data_d;
      fifo_mark_q <= fifo_mark_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pixel_simd_streamer.sv
// Scoreboarded bench for pixel_simd_streamer: full 64x64 frames plus a 4x1 one-beat frame.
module tb_pixel_simd_streamer;
  localparam int W = 64, H = 64, S = 4, AW = 10, DW = 8 * S;
  localparam int NB = H * W / S, BPR = W / S;

  logic clk = 1'b0;
  logic rst, start, m_ready, busy, done, mem_req, m_valid, m_sof, m_eol, m_eof;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, m_data;
  logic d_start, d_ready, d_busy, d_done, d_req, d_valid, d_sof, d_eol, d_eof;
  logic [0:0]    d_addr;
  logic [DW-1:0] d_rdata, d_data;

  int errors = 0, checks = 0;
  logic [DW+2:0] sb_q[$];
  int cyc = 0, hs_cnt = 0, req_cnt = 0, frames_done = 0, outstanding = 0;
  int first_hs_cyc = 0, eof_cyc = 0;
  logic [AW-1:0] exp_addr = '0;
  logic stall_q = 1'b0, expect_done = 1'b0, last_req = 1'b0, last_valid = 1'b0;
  logic [DW+3:0] held = '0;

  pixel_simd_streamer #(.WIDTH(W), .HEIGHT(H), .SIMD_WIDTH(S), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof));

  pixel_simd_streamer #(.WIDTH(4), .HEIGHT(1), .SIMD_WIDTH(S), .ADDR_W(1)) u_deg (
    .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
    .mem_req(d_req), .mem_addr(d_addr), .mem_rdata(d_rdata),
    .m_valid(d_valid), .m_ready(d_ready), .m_data(d_data),
    .m_sof(d_sof), .m_eol(d_eol), .m_eof(d_eof));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < S; k++) w[8*k +: 8] = 8'((S * n + k) % 256);
    return w;
  endfunction

  // One-cycle-latency memories; garbage when not requested exposes stale-data use.
  always @(posedge clk) begin
    mem_rdata <= mem_req ? word_of(int'(mem_addr)) : 32'hDEAD_BEEF;
    d_rdata   <= d_req ? word_of(int'(d_addr)) : 32'hBAD0_BAD0;
  end

  task automatic push_frame();
    for (int n = 0; n < NB; n++)
      sb_q.push_back({word_of(n), n == 0, (n % BPR) == BPR - 1, n == NB - 1});
  endtask

  // Drives one cycle and consumes the stream side against the scoreboard.
  task automatic step(input int pct, input logic st);
    logic hs;
    logic [DW+2:0] exp_b, act_b;
    start   = st;
    m_ready = ($urandom_range(99) < pct);
    @(negedge clk);
    hs = m_valid && m_ready;
    last_req = mem_req;
    last_valid = m_valid;
    if (mem_req) begin
      checks++;
      if (outstanding >= 2) begin
        errors++; $display("FAIL credit: mem_req with %0d committed, required < 2", outstanding);
      end
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++; $display("FAIL mem_addr: got %0d expected %0d", mem_addr, exp_addr);
      end
    end
    if (stall_q) begin
      checks++;
      if ({m_valid, m_data, m_sof, m_eol, m_eof} !== held) begin
        errors++; $display("FAIL stall_stable: got %h expected %h", {m_valid, m_data, m_sof, m_eol, m_eof}, held);
      end
    end
    if (done || expect_done) begin
      checks++;
      if (done !== expect_done) begin
        errors++; $display("FAIL done: got %b expected %b at cycle %0d", done, expect_done, cyc);
      end
      if (done) frames_done++;
    end
    expect_done = 1'b0;
    if (hs) begin
      act_b = {m_data, m_sof, m_eol, m_eof};
      checks++;
      if (sb_q.size() == 0) begin
        errors++; $display("FAIL beat: unexpected beat %h, scoreboard empty", act_b);
      end else begin
        exp_b = sb_q.pop_front();
        if (act_b !== exp_b) begin
          errors++; $display("FAIL beat: got %h expected %h", act_b, exp_b);
        end
      end
      if (m_sof) first_hs_cyc = cyc;
      if (m_eof) begin expect_done = 1'b1; eof_cyc = cyc; end
      hs_cnt++;
    end
    outstanding += int'(mem_req) - int'(hs);
    if (mem_req) begin exp_addr++; req_cnt++; end
    stall_q = m_valid && !m_ready;
    held = {m_valid, m_data, m_sof, m_eol, m_eof};
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic finish_frame(input int pct, input int target, input int bound);
    for (int c = 0; c < bound && frames_done < target; c++) step(pct, 1'b0);
    checks++;
    if (frames_done < target) begin
      errors++; $display("FAIL timeout: frames_done %0d expected %0d", frames_done, target);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL leftover: %0d beats missing, expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; d_start = 1'b0; d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    checks++;
    if ({busy, done, mem_req, m_valid, m_sof, m_eol, m_eof} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {busy, done, mem_req, m_valid, m_sof, m_eol, m_eof});
    end
    checks++;
    if ({mem_addr, m_data} !== '0) begin
      errors++; $display("FAIL reset_data: addr %h data %h expected 0", mem_addr, m_data);
    end
    checks++;
    if ({d_busy, d_done, d_req, d_valid, d_data} !== '0) begin
      errors++; $display("FAIL reset_deg: got %h expected 0", {d_busy, d_done, d_req, d_valid, d_data});
    end
  endtask

  task automatic test_full_ready();
    int c0, f0;
    f0 = frames_done; push_frame(); c0 = cyc;
    step(100, 1'b1);
    step(100, 1'b0);
    checks++;
    if (last_req !== 1'b1 || last_valid !== 1'b0) begin
      errors++; $display("FAIL first_req: req %b valid %b expected 1 0", last_req, last_valid);
    end
    step(100, 1'b0);
    checks++;
    if (last_valid !== 1'b1) begin
      errors++; $display("FAIL first_valid: got %b expected 1 at start+2", last_valid);
    end
    finish_frame(100, f0 + 1, 1200);
    checks++;
    if (first_hs_cyc != c0 + 2 || eof_cyc - first_hs_cyc != NB - 1) begin
      errors++; $display("FAIL throughput: first %0d last %0d expected %0d %0d", first_hs_cyc - c0, eof_cyc - first_hs_cyc, 2, NB - 1);
    end
  endtask

  task automatic test_random_ready();
    int f0;
    f0 = frames_done; push_frame();
    step(50, 1'b1);
    finish_frame(50, f0 + 1, 6000);
  endtask

  task automatic test_stall();
    int r0, f0;
    f0 = frames_done; push_frame(); r0 = req_cnt;
    step(0, 1'b1);
    repeat (20) step(0, 1'b0);
    checks++;
    if (req_cnt - r0 != 2) begin
      errors++; $display("FAIL stall_reads: got %0d reads expected 2", req_cnt - r0);
    end
    checks++;
    if (m_valid !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL stall_state: valid %b req %b expected 1 0", m_valid, mem_req);
    end
    finish_frame(100, f0 + 1, 1200);
  endtask

  task automatic test_back_to_back();
    int f0, h0, started;
    logic st;
    f0 = frames_done; h0 = hs_cnt; push_frame(); started = 1;
    step(100, 1'b1);
    for (int c = 0; c < 3000 && frames_done < f0 + 2; c++) begin
      st = busy ? 1'b1 : (done && started < 2);
      if (st && !busy) begin push_frame(); started++; end
      step(100, st);
    end
    repeat (5) step(100, 1'b0);
    checks++;
    if (frames_done != f0 + 2 || hs_cnt - h0 != 2 * NB) begin
      errors++; $display("FAIL back_to_back: frames %0d beats %0d expected 2 %0d", frames_done - f0, hs_cnt - h0, 2 * NB);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL leftover: %0d beats missing, expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int h0, f0;
    push_frame(); h0 = hs_cnt;
    step(100, 1'b1);
    for (int c = 0; c < 2000 && hs_cnt - h0 < 300; c++) step(100, 1'b0);
    rst = 1'b1;
    step(100, 1'b0);
    rst = 1'b0;
    checks++;
    if ({busy, done, mem_req, m_valid, m_sof, m_eol, m_eof, mem_addr, m_data} !== '0) begin
      errors++; $display("FAIL reset_mid: got %h expected 0", {busy, done, mem_req, m_valid, m_sof, m_eol, m_eof, mem_addr, m_data});
    end
    sb_q.delete(); outstanding = 0; exp_addr = '0; stall_q = 1'b0; expect_done = 1'b0;
    f0 = frames_done;
    repeat (5) step(100, 1'b0);
    checks++;
    if (frames_done != f0) begin
      errors++; $display("FAIL reset_done: got %0d done pulses expected 0", frames_done - f0);
    end
    push_frame();
    step(100, 1'b1);
    finish_frame(100, f0 + 1, 1200);
  endtask

  task automatic test_degenerate();
    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    @(negedge clk);
    checks++;
    if (d_req !== 1'b1 || d_valid !== 1'b0 || d_busy !== 1'b1) begin
      errors++; $display("FAIL deg_req: req %b valid %b busy %b expected 1 0 1", d_req, d_valid, d_busy);
    end
    @(negedge clk);
    checks++;
    if ({d_valid, d_sof, d_eol, d_eof, d_data} !== {4'b1111, word_of(0)}) begin
      errors++; $display("FAIL deg_beat: got %h expected %h", {d_valid, d_sof, d_eol, d_eof, d_data}, {4'b1111, word_of(0)});
    end
    @(negedge clk);
    checks++;
    if ({d_done, d_valid, d_busy} !== 3'b100) begin
      errors++; $display("FAIL deg_done: got %b expected 100", {d_done, d_valid, d_busy});
    end
    @(negedge clk);
    checks++;
    if (d_done !== 1'b0) begin
      errors++; $display("FAIL deg_done_once: got %b expected 0", d_done);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full_ready();
    test_random_ready();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_degenerate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
